// File: rtl/dv_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dv_ctrl_seq
//  Description : Multi-channel bench controller. Releases the DUT reset,
//                starts each channel as it becomes active, latches per-channel
//                completion and failure, drains, then issues a terminal
//                PASS/FAIL verdict. A cycle-count watchdog bounds the run.
//  Option      : DV_CTRL_FINISH_EN - when defined, prints the verdict and
//                calls $finish one cycle after done rises (simulation only).
//  Revision    : 1.0 - initial release
// ============================================================================
module dv_ctrl_seq #(
   parameter int             N          = 4,
   parameter logic [N-1:0]   CH_MASK    = {N{1'b1}},
   parameter int             RST_CYCLES = 20,
   parameter int             TIMEOUT    = 10000,
   parameter int             DRAIN      = 16,
   parameter int             CW         = 32
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic [N-1:0]  dut_active_i,
   input  logic [N-1:0]  stim_done_i,
   input  logic [N-1:0]  test_done_i,
   input  logic [N-1:0]  test_fail_i,
   output logic          dut_nreset_o,
   output logic [N-1:0]  start_o,
   output logic          done_o,
   output logic          pass_o,
   output logic          timeout_o,
   output logic [N-1:0]  fail_ch_o,
   output logic [CW-1:0] cycles_o,
   output logic [2:0]    state_o
);

   // Elaboration-time guards on parameter ranges and counter width
   if (N < 1 || N > 32 || RST_CYCLES < 1 || DRAIN < 1 || TIMEOUT < 1) begin : g_bad_range
      $error("dv_ctrl_seq: parameter out of range");
   end
   if (((longint'(RST_CYCLES) >> CW) != 0) || ((longint'(TIMEOUT) >> CW) != 0) ||
       ((longint'(DRAIN) >> CW) != 0)) begin : g_bad_width
      $error("dv_ctrl_seq: RST_CYCLES/TIMEOUT/DRAIN do not fit in CW bits");
   end

   // Terminal compare values: each phase ends on the edge where the counter
   // has already seen (limit-1) cycles, so the transition lands on edge 'limit'.
   localparam logic [CW-1:0] C_RST_LAST   = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] C_TO_LAST    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_DRAIN_LAST = CW'(DRAIN - 1);

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_WAIT_ACT = 3'd1,
      S_RUN      = 3'd2,
      S_DRAIN    = 3'd3,
      S_PASS     = 3'd4,
      S_FAIL     = 3'd5
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cycles_q;
   logic          dut_nreset_q;
   logic          done_q;
   logic          pass_q;
   logic          timeout_q;
   logic [N-1:0]  start_q;
   logic [N-1:0]  sdone_q;
   logic [N-1:0]  tdone_q;
   logic [N-1:0]  fail_q;

   // Next values of the sticky latches; completion looks at these so a done
   // arriving on the watchdog's last cycle still counts.
   logic [N-1:0]  w_sdone_d;
   logic [N-1:0]  w_tdone_d;
   logic [N-1:0]  w_fail_d;
   logic [N-1:0]  w_act;
   logic          w_all_act;
   logic          w_complete;
   logic          w_counting;

   assign w_sdone_d  = sdone_q | (stim_done_i & start_q);
   assign w_tdone_d  = tdone_q | (test_done_i & start_q);
   assign w_fail_d   = fail_q | (test_fail_i & CH_MASK);
   assign w_act      = dut_active_i & CH_MASK;
   assign w_all_act  = &(dut_active_i | ~CH_MASK);
   assign w_complete = &((w_sdone_d & w_tdone_d) | ~CH_MASK);
   assign w_counting = dut_nreset_q && (state_q != S_PASS) && (state_q != S_FAIL);

   // Sequencer FSM with all registered outputs, latches and counters
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= S_RESET;
         cnt_q        <= '0;
         cycles_q     <= '0;
         dut_nreset_q <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         start_q      <= '0;
         sdone_q      <= '0;
         tdone_q      <= '0;
         fail_q       <= '0;
      end else begin
         if (w_counting && (cycles_q != {CW{1'b1}})) begin
            cycles_q <= cycles_q + 1'b1;
         end
         case (state_q)
            S_RESET: begin
               if (cnt_q == C_RST_LAST) begin
                  dut_nreset_q <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= S_WAIT_ACT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WAIT_ACT: begin
               start_q <= start_q | w_act;
               fail_q  <= w_fail_d;
               if (cnt_q == C_TO_LAST) begin
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_FAIL;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (w_all_act) begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               start_q <= start_q | w_act;
               fail_q  <= w_fail_d;
               sdone_q <= w_sdone_d;
               tdone_q <= w_tdone_d;
               if (w_complete) begin
                  cnt_q   <= '0;
                  state_q <= S_DRAIN;
               end else if (cnt_q == C_TO_LAST) begin
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_FAIL;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DRAIN: begin
               fail_q <= w_fail_d;
               if (cnt_q == C_DRAIN_LAST) begin
                  done_q  <= 1'b1;
                  pass_q  <= ~|w_fail_d;
                  state_q <= (|w_fail_d) ? S_FAIL : S_PASS;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               // PASS/FAIL are terminal: hold everything
            end
         endcase
      end
   end

   assign dut_nreset_o = dut_nreset_q;
   assign start_o      = start_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign timeout_o    = timeout_q;
   assign fail_ch_o    = fail_q;
   assign cycles_o     = cycles_q;
   assign state_o      = state_q;

`ifdef DV_CTRL_FINISH_EN
   // Report the verdict one cycle after done rises and end the simulation
   always @(posedge clk) begin
      if (done_q) begin
         $display("%s cycles=%0d fail_ch=%0h timeout=%0d",
                  pass_q ? "PASS" : "FAIL", cycles_q, fail_q, timeout_q);
         $finish;
      end
   end
`else
   // Verdict is consumed by the surrounding bench through done_o/pass_o
`endif

endmodule
`default_nettype wire

// File: tb/tb_dv_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dv_ctrl_seq
//  Description : Directed, table-driven bench for dv_ctrl_seq. Each table row
//                is a full run with its own stimulus schedule and expected
//                verdict, timing and status; a second instance covers the
//                channel mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dv_ctrl_seq;

   logic        clk;
   logic        nreset;
   logic [3:0]  dut_active, stim_done, test_done, test_fail;
   logic        dut_nreset, done, pass, timeout;
   logic [3:0]  start, fail_ch;
   logic [31:0] cycles;
   logic [2:0]  state;

   logic [3:0]  m_active, m_stim, m_tdone, m_fail;
   logic        m_dut_nreset, m_done, m_pass, m_timeout;
   logic [3:0]  m_start, m_fail_ch;
   logic [31:0] m_cycles;
   logic [2:0]  m_state;

   int n_checks = 0;
   int n_err    = 0;
   int edge_n   = 0;

   dv_ctrl_seq #(.N(4), .CH_MASK(4'hF), .RST_CYCLES(20), .TIMEOUT(500),
                 .DRAIN(16), .CW(32)) u_dut (
      .clk(clk), .nreset(nreset),
      .dut_active_i(dut_active), .stim_done_i(stim_done),
      .test_done_i(test_done), .test_fail_i(test_fail),
      .dut_nreset_o(dut_nreset), .start_o(start), .done_o(done),
      .pass_o(pass), .timeout_o(timeout), .fail_ch_o(fail_ch),
      .cycles_o(cycles), .state_o(state));

   dv_ctrl_seq #(.N(4), .CH_MASK(4'b0011), .RST_CYCLES(20), .TIMEOUT(500),
                 .DRAIN(16), .CW(32)) u_dut_m (
      .clk(clk), .nreset(nreset),
      .dut_active_i(m_active), .stim_done_i(m_stim),
      .test_done_i(m_tdone), .test_fail_i(m_fail),
      .dut_nreset_o(m_dut_nreset), .start_o(m_start), .done_o(m_done),
      .pass_o(m_pass), .timeout_o(m_timeout), .fail_ch_o(m_fail_ch),
      .cycles_o(m_cycles), .state_o(m_state));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         fail_at;     // edge after which test_fail is pulsed (-1 none)
      logic [3:0] fail_mask;
      int         tdone_at;    // edge after which test_done is pulsed
      logic [3:0] tdone_mask;
      int         early_at;    // extra all-channel test_done pulse (-1 none)
      int         abort_at;    // edge at which nreset is pulsed mid-run (-1 none)
      logic [2:0] e_state;
      logic       e_pass;
      logic       e_to;
      logic [3:0] e_fail;
      int         e_done;      // edge (after nreset release) where done rises
      int         e_cyc;
      logic       e_drain;     // DRAIN state observed
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v, input int k);
      dut_active = (k >= 45) ? 4'hF : 4'h0;
      stim_done  = (k == 50) ? 4'hF : 4'h0;
      test_done  = ((k == v.tdone_at) ? v.tdone_mask : 4'h0) |
                   ((k == v.early_at) ? 4'hF : 4'h0);
      test_fail  = (k == v.fail_at) ? v.fail_mask : 4'h0;
      m_active   = dut_active & 4'b0011;
      m_stim     = stim_done & 4'b0011;
      m_tdone    = 4'b0011 & ((k == 60) ? 4'hF : 4'h0);
      m_fail     = 4'h0;
   endtask

   task automatic clear_inputs();
      {dut_active, stim_done, test_done, test_fail} = '0;
      {m_active, m_stim, m_tdone, m_fail} = '0;
   endtask

   function automatic logic [46:0] main_outs();
      return {state, dut_nreset, start, done, pass, timeout, fail_ch, cycles};
   endfunction

   function automatic logic [46:0] mask_outs();
      return {m_state, m_dut_nreset, m_start, m_done, m_pass, m_timeout, m_fail_ch, m_cycles};
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int  nrst_edge, start_edge, done_edge;
      bit  drain_seen, aborted;
      string tag;
      tag = $sformatf("v%0d", idx);
      nrst_edge = -1; start_edge = -1; done_edge = -1;
      drain_seen = 0; aborted = 0;
      clear_inputs();
      nreset = 1'b0;
      tick(); tick();
      check({tag, "_rst_vals"}, {17'd0, main_outs()}, 64'd0);
      nreset = 1'b1;
      edge_n = 0;
      while (done_edge < 0 && edge_n < 700) begin
         drive(v, edge_n);
         tick();
         edge_n++;
         if (nrst_edge < 0 && dut_nreset) nrst_edge = edge_n;
         if (start_edge < 0 && start == 4'hF) start_edge = edge_n;
         if (state == 3'd3) drain_seen = 1;
         if (done) done_edge = edge_n;
         if (!aborted && edge_n == v.abort_at) begin
            check({tag, "_pre_abort_state"}, 64'(state), 64'd2);
            nreset = 1'b0;
            #2;
            check({tag, "_async_rst_vals"}, {17'd0, main_outs()}, 64'd0);
            clear_inputs();
            tick(); tick(); tick();
            check({tag, "_held_rst_vals"}, {17'd0, mask_outs()}, 64'd0);
            nreset = 1'b1;
            edge_n = 0;
            nrst_edge = -1; start_edge = -1; drain_seen = 0;
            aborted = 1;
         end
      end
      if (done_edge < 0) begin
         n_checks++; n_err++;
         $display("FAIL %s_done_wait: done never rose within 700 cycles", tag);
      end
      check({tag, "_nrst_edge"}, 64'(nrst_edge), 64'd20);
      check({tag, "_start_edge"}, 64'(start_edge), 64'd46);
      check({tag, "_done_edge"}, 64'(done_edge), 64'(v.e_done));
      check({tag, "_state"}, 64'(state), 64'(v.e_state));
      check({tag, "_pass"}, 64'(pass), 64'(v.e_pass));
      check({tag, "_timeout"}, 64'(timeout), 64'(v.e_to));
      check({tag, "_fail_ch"}, 64'(fail_ch), 64'(v.e_fail));
      check({tag, "_cycles"}, 64'(cycles), 64'(v.e_cyc));
      check({tag, "_start"}, 64'(start), 64'hF);
      check({tag, "_dut_nreset"}, 64'(dut_nreset), 64'd1);
      check({tag, "_drain_seen"}, 64'(drain_seen), 64'(v.e_drain));
      // Terminal: a few more cycles with noisy inputs must change nothing
      dut_active = 4'h0; stim_done = 4'hF; test_done = 4'hF; test_fail = 4'hF;
      tick(); tick(); tick();
      check({tag, "_terminal_hold"},
            {29'd0, state, pass, timeout, fail_ch, done, start, dut_nreset, cycles[19:0]},
            {29'd0, v.e_state, v.e_pass, v.e_to, v.e_fail, 1'b1, 4'hF, 1'b1, 20'(v.e_cyc)});
   endtask

   initial begin
      nreset = 1'b0;
      clear_inputs();
      //          fail_at fmask tdone tmask  early abort  st    pass  to    fail   done cyc  drain
      vecs[0] = '{-1,  4'h0, 60,  4'hF, -1,  -1,  3'd4, 1'b1, 1'b0, 4'h0,  77,  57,  1'b1}; // clean pass
      vecs[1] = '{70,  4'h4, 60,  4'hF, -1,  -1,  3'd5, 1'b0, 1'b0, 4'h4,  77,  57,  1'b1}; // fail during DRAIN
      vecs[2] = '{55,  4'h1, 60,  4'hF, -1,  -1,  3'd5, 1'b0, 1'b0, 4'h1,  77,  57,  1'b1}; // fail during RUN
      vecs[3] = '{30,  4'h2, 60,  4'hF, -1,  -1,  3'd5, 1'b0, 1'b0, 4'h2,  77,  57,  1'b1}; // fail during WAIT_ACT
      vecs[4] = '{10,  4'h8, 60,  4'hF, -1,  -1,  3'd4, 1'b1, 1'b0, 4'h0,  77,  57,  1'b1}; // fail during RESET ignored
      vecs[5] = '{-1,  4'h0, 60,  4'h7, -1,  -1,  3'd5, 1'b0, 1'b1, 4'h0, 520, 500,  1'b0}; // ch3 never done: timeout
      vecs[6] = '{-1,  4'h0, 519, 4'hF, -1,  -1,  3'd4, 1'b1, 1'b0, 4'h0, 536, 516,  1'b1}; // done on timeout cycle
      vecs[7] = '{-1,  4'h0, 520, 4'hF, -1,  -1,  3'd5, 1'b0, 1'b1, 4'h0, 520, 500,  1'b0}; // done one cycle late
      vecs[8] = '{-1,  4'h0, 100, 4'hF, 40,  -1,  3'd4, 1'b1, 1'b0, 4'h0, 117,  97,  1'b1}; // early test_done ignored
      vecs[9] = '{-1,  4'h0, 60,  4'hF, -1,  55,  3'd4, 1'b1, 1'b0, 4'h0,  77,  57,  1'b1}; // mid-RUN abort + restart

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], i);
         if (i == 0) begin
            // Masked instance ran alongside the clean-pass schedule
            check("mask_state", 64'(m_state), 64'd4);
            check("mask_pass", 64'(m_pass), 64'd1);
            check("mask_start", 64'(m_start), 64'h3);
            check("mask_fail_timeout", {59'd0, m_fail_ch, m_timeout}, 64'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
